// File: rtl/multicycle_processor_if.sv
// Instruction-fetch bus and writeback observation port of the multicycle core.
//
// Fetch handshake (valid/ready semantics):
//   imem_req is the request valid and imem_ack is the ready/response strobe.
//   A fetch transfers on the rising edge where imem_req && imem_ack are both
//   high, and imem_rdata is taken on that edge. While imem_req is high without
//   imem_ack, imem_req and imem_addr stay stable. imem_ack is ignored whenever
//   imem_req is low.
`timescale 1ns/1ps
interface multicycle_processor_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            zero;
  logic            wb_valid;
  logic [4:0]      wb_reg;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [2:0]      state;     // debug view of the control FSM

  modport master (
    output imem_req, imem_addr, zero, wb_valid, wb_reg, wb_data, illegal, state,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, zero, wb_valid, wb_reg, wb_data, illegal, state,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle RV32I-subset integer core: register-register and
// register-immediate ALU ops, IDLE/FETCH/DECODE/EXECUTE/WRITEBACK control.
`timescale 1ns/1ps
module multicycle_processor #(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_processor_if.master  bus
);

  localparam int        RW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int        SHW = $clog2(XLEN);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } alu_op_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, imm_q, r_q;
  logic [XLEN-1:0] rf [NUM_REGS];

  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic            zero_q;
  logic            wb_valid_q;
  logic [4:0]      wb_reg_q;
  logic [XLEN-1:0] wb_data_q;
  logic            illegal_q;

  // Instruction fields
  logic [6:0] opcode, funct7, shift_f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  // On RV64 the shift amount borrows IR[25], so only IR[31:26] encode the op.
  assign shift_f7 = (XLEN == 64) ? {ir_q[31:26], 1'b0} : ir_q[31:25];

  logic    is_r, is_i, f7_ok, regs_ok, legal;
  alu_op_t op;

  // Decode the latched instruction into an ALU op and a legality verdict.
  always_comb begin
    is_r  = (opcode == 7'h33);
    is_i  = (opcode == 7'h13);
    op    = OP_ADD;
    f7_ok = 1'b0;
    if (is_r) begin
      f7_ok = (funct7 == 7'h00);
      case (funct3)
        3'd0: begin op = funct7[5] ? OP_SUB : OP_ADD; f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20); end
        3'd1: op = OP_SLL;
        3'd2: op = OP_SLT;
        3'd3: op = OP_SLTU;
        3'd4: op = OP_XOR;
        3'd5: begin op = funct7[5] ? OP_SRA : OP_SRL; f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20); end
        3'd6: op = OP_OR;
        default: op = OP_AND;
      endcase
    end else if (is_i) begin
      f7_ok = 1'b1;
      case (funct3)
        3'd0: op = OP_ADD;
        3'd1: begin op = OP_SLL; f7_ok = (shift_f7 == 7'h00); end
        3'd2: op = OP_SLT;
        3'd3: op = OP_SLTU;
        3'd4: op = OP_XOR;
        3'd5: begin
          op    = ir_q[30] ? OP_SRA : OP_SRL;
          f7_ok = (shift_f7 == (ir_q[30] ? 7'h20 : 7'h00));
        end
        3'd6: op = OP_OR;
        default: op = OP_AND;
      endcase
    end
    regs_ok = ({1'b0, rd} < NR) && ({1'b0, rs1} < NR) && (!is_r || ({1'b0, rs2} < NR));
    legal   = (is_r || is_i) && f7_ok && regs_ok;
  end

  logic [XLEN-1:0] op2, alu;
  logic [SHW-1:0]  shamt;

  // ALU on the operand registers; second operand is B for R-type, imm for I-type.
  always_comb begin
    op2   = is_r ? b_q : imm_q;
    shamt = is_r ? b_q[SHW-1:0] : ir_q[20 +: SHW];
    case (op)
      OP_ADD:  alu = a_q + op2;
      OP_SUB:  alu = a_q - op2;
      OP_SLL:  alu = a_q << shamt;
      OP_SLT:  alu = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op2))};
      OP_SLTU: alu = {{(XLEN-1){1'b0}}, (a_q < op2)};
      OP_XOR:  alu = a_q ^ op2;
      OP_SRL:  alu = a_q >> shamt;
      OP_SRA:  alu = $signed(a_q) >>> shamt;
      OP_OR:   alu = a_q | op2;
      default: alu = a_q & op2;
    endcase
  end

  logic [XLEN-1:0] rd_a, rd_b, imm_ext;
  assign rd_a    = (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];
  assign rd_b    = (rs2 == 5'd0) ? '0 : rf[rs2[RW-1:0]];
  assign imm_ext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};

  // Control FSM, datapath registers, register file and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      r_q        <= '0;
      req_q      <= 1'b0;
      addr_q     <= PC_RESET;
      zero_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= rd_a;
          b_q     <= rd_b;
          imm_q   <= imm_ext;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          // The commit pulses are set here so they are high exactly in WRITEBACK.
          if (legal) begin
            r_q        <= alu;
            zero_q     <= (alu == '0);
            wb_valid_q <= (rd != 5'd0);
            if (rd != 5'd0) begin
              wb_reg_q  <= rd;
              wb_data_q <= alu;
            end
          end else begin
            illegal_q <= 1'b1;
          end
          state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (wb_valid_q) rf[rd[RW-1:0]] <= r_q;
          wb_valid_q <= 1'b0;
          illegal_q  <= 1'b0;
          pc_q       <= pc_q + XLEN'(4);
          addr_q     <= pc_q + XLEN'(4);
          req_q      <= 1'b1;
          state_q    <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.zero      = zero_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.illegal   = illegal_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_processor.sv
// Bench for multicycle_processor: program replay with per-instruction
// expected commit events, fetch-stall timing, illegal ops, x0 writes,
// asynchronous mid-instruction reset, and a NUM_REGS=16 variant.
`timescale 1ns/1ps
module tb_multicycle_processor;

  localparam int W     = 40;   // {illegal, wb_valid, wb_reg, wb_data, zero}
  localparam int NPROG = 16;

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic reset2 = 1'b0;
  int   cyc    = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multicycle_processor_if #(.XLEN(32)) bus ();
  multicycle_processor_if #(.XLEN(32)) bus2 ();

  multicycle_processor #(.XLEN(32), .NUM_REGS(32), .PC_RESET(32'h0)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  multicycle_processor #(.XLEN(32), .NUM_REGS(16), .PC_RESET(32'h0)) dut2 (
    .clock(clock), .reset(reset2), .bus(bus2)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int           start_q[$];
  int           lat_q[$];
  logic [31:0]  prog [NPROG];
  logic [W-1:0] prog_exp [NPROG];
  logic [31:0]  prog2 [2];

  logic [31:0] exp_pc = 32'h0;
  int  retired     = 0;
  int  release_cyc = 0;
  bit  first_req_pending = 1'b0;
  bit  first_wb_pending  = 1'b0;
  bit  in_fetch    = 1'b0;
  int  req_start   = 0;
  logic [31:0] fetch_addr = 32'h0;
  int  stall_left  = 0;
  int  stall_total = 0;
  bit  stall_done  = 1'b0;
  int  stall_idx   = 2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic ill, input logic wb, input logic [4:0] rd,
                                      input logic [31:0] d, input logic z);
    return {ill, wb, rd, d, z};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},      bus.imem_req,  1'b0);
    check({tag, "_addr"},     bus.imem_addr, 32'h0);
    check({tag, "_zero"},     bus.zero,      1'b0);
    check({tag, "_wb_valid"}, bus.wb_valid,  1'b0);
    check({tag, "_wb_reg"},   bus.wb_reg,    5'd0);
    check({tag, "_wb_data"},  bus.wb_data,   32'h0);
    check({tag, "_illegal"},  bus.illegal,   1'b0);
    check({tag, "_state"},    bus.state,     3'd0);
  endtask

  // ---------------- instruction memory driver (DUT 1) ----------------
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bus.imem_ack = 1'b0;
        in_fetch     = 1'b0;
      end else begin
        if (in_fetch) begin
          check("stall_req",  bus.imem_req,  1'b1);
          check("stall_addr", bus.imem_addr, fetch_addr);
        end else if (bus.imem_req) begin
          in_fetch   = 1'b1;
          req_start  = cyc;
          fetch_addr = bus.imem_addr;
          if (first_req_pending) begin
            check("first_req_cycle", cyc - release_cyc + 1, 2);
            first_req_pending = 1'b0;
          end
          stall_total = 0;
          if (int'(fetch_addr >> 2) == stall_idx && !stall_done) begin
            stall_left  = 3;
            stall_total = 3;
            stall_done  = 1'b1;
          end
        end
        bus.imem_ack = 1'b0;
        if (in_fetch) begin
          if (stall_left > 0) begin
            stall_left--;
          end else if (fetch_addr < 32'(NPROG * 4)) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = prog[fetch_addr[5:2]];
            check("fetch_addr", fetch_addr, exp_pc);
            exp_q.push_back(prog_exp[fetch_addr[5:2]]);
            start_q.push_back(req_start);
            lat_q.push_back(3 + stall_total);
            exp_pc   = exp_pc + 32'd4;
            in_fetch = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- commit monitor (DUT 1) ----------------
  initial begin
    logic [W-1:0] e, got;
    int s, l;
    forever begin
      @(negedge clock);
      if (reset && bus.state == 3'd4) begin
        got = {bus.illegal, bus.wb_valid,
               bus.wb_valid ? bus.wb_reg : 5'd0,
               bus.wb_valid ? bus.wb_data : 32'h0,
               bus.zero};
        if (exp_q.size() == 0) begin
          check("wb_unexpected", got, '0);
          check("wb_unexpected_event", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          s = start_q.pop_front();
          l = lat_q.pop_front();
          check("wb_event", got, e);
          check("wb_latency", cyc - s, l);
          if (first_wb_pending) begin
            check("first_wb_cycle", cyc - release_cyc + 1, 5);
            first_wb_pending = 1'b0;
          end
        end
        retired++;
      end else if (reset && (bus.wb_valid || bus.illegal)) begin
        check("stray_pulse", {bus.wb_valid, bus.illegal}, 2'b00);
      end
    end
  end

  // ---------------- instruction memory driver (DUT 2) ----------------
  initial begin
    bus2.imem_ack   = 1'b0;
    bus2.imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      bus2.imem_ack   = reset2 && bus2.imem_req && (bus2.imem_addr < 32'd8);
      bus2.imem_rdata = prog2[bus2.imem_addr[2]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic release_dut1();
    @(negedge clock);
    reset             = 1'b1;
    release_cyc       = cyc;
    first_req_pending = 1'b1;
    first_wb_pending  = 1'b1;
    exp_pc            = 32'h0;
  endtask

  task automatic wait_retired(input string tag, input int target);
    int k;
    for (k = 0; k < 300; k++) begin
      if (retired >= target) break;
      @(negedge clock);
    end
    if (k == 300) check(tag, retired, target);
  endtask

  task automatic wait_state2(input string tag, input logic [2:0] st);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus2.state == st) break;
    end
    if (k == 50) check(tag, bus2.state, st);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    prog[0]  = 32'h00500093; prog_exp[0]  = ev(0, 1, 5'd1,  32'h00000005, 0);
    prog[1]  = 32'hFFD00113; prog_exp[1]  = ev(0, 1, 5'd2,  32'hFFFFFFFD, 0);
    prog[2]  = 32'h002081B3; prog_exp[2]  = ev(0, 1, 5'd3,  32'h00000002, 0);
    prog[3]  = 32'h40108233; prog_exp[3]  = ev(0, 1, 5'd4,  32'h00000000, 1);
    prog[4]  = 32'h0000006F; prog_exp[4]  = ev(1, 0, 5'd0,  32'h00000000, 1);
    prog[5]  = 32'h40115293; prog_exp[5]  = ev(0, 1, 5'd5,  32'hFFFFFFFE, 0);
    prog[6]  = 32'h00700013; prog_exp[6]  = ev(0, 0, 5'd0,  32'h00000000, 0);
    prog[7]  = 32'h00000333; prog_exp[7]  = ev(0, 1, 5'd6,  32'h00000000, 1);
    prog[8]  = 32'h0020C3B3; prog_exp[8]  = ev(0, 1, 5'd7,  32'hFFFFFFF8, 0);
    prog[9]  = 32'h00112433; prog_exp[9]  = ev(0, 1, 5'd8,  32'h00000001, 0);
    prog[10] = 32'h001134B3; prog_exp[10] = ev(0, 1, 5'd9,  32'h00000000, 1);
    prog[11] = 32'h00409513; prog_exp[11] = ev(0, 1, 5'd10, 32'h00000050, 0);
    prog[12] = 32'h01C15593; prog_exp[12] = ev(0, 1, 5'd11, 32'h0000000F, 0);
    prog[13] = 32'h02208633; prog_exp[13] = ev(1, 0, 5'd0,  32'h00000000, 0);
    prog[14] = 32'hFFF0B693; prog_exp[14] = ev(0, 1, 5'd13, 32'h00000001, 0);
    prog[15] = 32'h0F017713; prog_exp[15] = ev(0, 1, 5'd14, 32'h000000F0, 0);
    prog2[0] = 32'h00100A13;   // ADDI x20,x0,1: x20 does not exist with 16 regs
    prog2[1] = 32'h00900193;   // ADDI x3,x0,9

    // Reset values while reset is held.
    repeat (3) @(negedge clock);
    check_reset_values("rst");

    // Full program run, with a 3-cycle stall on the third fetch.
    release_dut1();
    wait_retired("run1_timeout", NPROG);
    repeat (2) @(negedge clock);
    check("run1_queue_empty", exp_q.size(), 0);
    check("run1_end_addr", bus.imem_addr, 32'h40);
    check("run1_end_req", bus.imem_req, 1'b1);

    // Restart, then abort with reset while in EXECUTE of the SRAI.
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    release_dut1();
    wait_retired("run2_timeout", NPROG + 5);
    for (k = 0; k < 20; k++) begin
      if (bus.state == 3'd3) break;
      @(negedge clock);
    end
    if (k == 20) check("mid_execute_timeout", bus.state, 3'd3);
    check("mid_zero_before", bus.zero, 1'b1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    start_q.delete();
    lat_q.delete();
    #1;
    check_reset_values("mid_rst");
    for (k = 0; k < 3; k++) begin
      @(negedge clock);
      check("mid_rst_no_wb", {bus.wb_valid, bus.illegal}, 2'b00);
    end
    retired = 0;
    release_dut1();
    wait_retired("run3_timeout", 3);

    // NUM_REGS=16 variant: out-of-range rd is illegal.
    @(negedge clock);
    reset2 = 1'b1;
    wait_state2("nr16_wb1_timeout", 3'd4);
    check("nr16_illegal", {bus2.illegal, bus2.wb_valid}, 2'b10);
    @(negedge clock);
    wait_state2("nr16_wb2_timeout", 3'd4);
    check("nr16_addi", {bus2.illegal, bus2.wb_valid, bus2.wb_reg, bus2.wb_data},
          {1'b0, 1'b1, 5'd3, 32'd9});
    @(negedge clock);
    check("nr16_next_addr", bus2.imem_addr, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multi-cycle RV32I-subset integer core, the successor to the single-cycle R-type processor top. It implements register-register and register-immediate ALU instructions and is generic in data width (XLEN) and register count (NUM_REGS). It fetches over a req/ack instruction-memory handshake, so instruction memory may stall, and it exposes a writeback observation port for verification.

## Interface
- XLEN, 32, datapath and register width; legal values 32 or 64.
- NUM_REGS, 32, architectural register count; power of two, 2..32; x0 reads as zero.
- PC_RESET, 0, PC value loaded on reset; XLEN bits wide.
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  XLEN  byte address of the fetch (current PC).
- imem_ack  in  1  instruction valid this cycle; sampled only in FETCH.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack.
- zero  out  1  registered flag: last ALU result == 0.
- wb_valid  out  1  one-cycle pulse when a register write commits.
- wb_reg  out  5  destination index of the commit.
- wb_data  out  XLEN  data written.
- illegal  out  1  one-cycle pulse when an instruction is retired as illegal.

## Operation
- FSM states: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH.
- IDLE: entered on reset; leaves unconditionally after one cycle.
- FETCH: imem_req=1, imem_addr=PC. The FSM stays here until imem_ack=1, then latches imem_rdata into IR.
- DECODE: reads rs1 (IR[19:15]) and rs2 (IR[24:20]) into operand registers A and B, and sign-extends IR[31:20] to XLEN as the immediate.
- EXECUTE: computes the ALU result into register R and updates zero to (R == 0).
- WRITEBACK:
  - If the instruction is legal and rd != 0, writes R to rd and pulses wb_valid, with wb_reg=rd and wb_data=R.
  - Then PC <= PC + 4, modulo 2^XLEN.
- R-type (opcode 0x33): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, decoded by funct3 and funct7.
  - SUB and SRA require funct7 = 0x20.
  - Every other op requires funct7 = 0x00.
- I-type (opcode 0x13): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - SRAI is selected by IR[30]=1.
- Shift amount:
  - R-type uses B[log2(XLEN)-1:0].
  - I-type uses IR[24:20] when XLEN=32 and IR[25:20] when XLEN=64.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. The result is 0 or 1, zero-extended.
- Arithmetic wraps modulo 2^XLEN. There is no overflow flag.
- An instruction is illegal if any of the following holds:
  - the opcode is neither 0x33 nor 0x13;
  - the funct7 encoding is not allowed for the operation;
  - any used register index is >= NUM_REGS.
- An illegal instruction still passes through all states. zero is not updated, there is no register write, illegal pulses in WRITEBACK, and PC advances by 4.
- x0 is never written. A read of x0 returns 0.

## Timing
- Reset values:
  - state=IDLE, PC=PC_RESET, all registers and IR/A/B/R = 0;
  - imem_req=0, imem_addr=PC_RESET, zero=0, wb_valid=0, wb_reg=0, wb_data=0, illegal=0.
- The first imem_req rises in the second cycle after reset deasserts: one cycle in IDLE, then FETCH.
- Throughput is 4 cycles per instruction when imem_ack is high on the first FETCH cycle. Each cycle of ack-low adds one cycle.
- Given ack in cycle n: DECODE is n+1, EXECUTE is n+2, WRITEBACK/wb_valid is n+3, and the next imem_req is n+4.
- While stalled in FETCH, imem_addr and imem_req hold stable. imem_ack outside FETCH is ignored.
- A read in DECODE sees every write made in a prior WRITEBACK (no bypass needed).
- Reset asserted mid-instruction aborts immediately and asynchronously:
  - no wb_valid and no illegal pulse are emitted;
  - all state returns to the reset values.
- wb_valid and illegal are never both high in the same cycle.

## Test plan
- Reset then program at PC 0 with ack always high: 0x00500093 (ADDI x1,x0,5), 0xFFD00113 (ADDI x2,x0,-3).
  - Required: wb x1=0x5 at cycle 5, then wb x2=0xFFFFFFFD 4 cycles later.
  - Required: imem_addr steps 0x0, 0x4, 0x8.
- Continue: 0x002081B3 (ADD x3,x1,x2) -> wb x3=0x2, zero=0. Then 0x40108233 (SUB x4,x1,x1) -> wb x4=0x0, zero=1. Then 0x40115293 (SRAI x5,x2,1) -> wb x5=0xFFFFFFFE.
- Stall: hold imem_ack low for 3 cycles in FETCH.
  - Required: imem_req=1 and imem_addr constant throughout.
  - Required: the instruction retires exactly 3 cycles later than with no stall.
- Illegal: fetch 0x0000006F (JAL).
  - Required: illegal pulses one cycle, no wb_valid, zero unchanged, next imem_addr = PC+4.
  - With NUM_REGS=16: ADDI x20,x0,1 (0x00100A13) -> illegal pulse, no write.
- Writes to x0: 0x00700013 (ADDI x0,x0,7) -> no wb_valid, and a following ADD x6,x0,x0 writes 0.
- Reset mid-op: deassert-to-assert reset while in EXECUTE.
  - Required: outputs return to reset values in the same cycle, no wb_valid.
  - Required: after release, the first fetch is from PC_RESET.
